// File: rtl/ascon_pkg.sv
// ascon_pkg: shared Ascon constants, state-word type and controller FSM encoding.
package ascon_pkg;
   localparam int W = 64;
   localparam logic [W-1:0] IV_HASH = 64'h00400c0000000100;
   localparam logic [W-1:0] IV_XOF  = 64'h00400c0000000000;
   typedef logic [W-1:0] word_t;
   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_ABSORB, S_PERM_A, S_FINAL, S_SQUEEZE, S_PERM_S
   } state_t;
endpackage

// File: rtl/ascon_pad64.sv
// ascon_pad64: masks the final message word to its valid bytes and appends the 0x80 pad byte.
module ascon_pad64
   import ascon_pkg::*;
(
   input  word_t      data,
   input  logic [2:0] bytes,
   input  logic       last,
   output word_t      word
);
   logic [5:0] sh;
   word_t      mask, pad;
   always_comb begin
      sh   = {bytes, 3'b000};
      mask = ~({W{1'b1}} >> sh);
      pad  = 64'h8000_0000_0000_0000 >> sh;
      word = last ? ((data & mask) ^ pad) : data;
   end
endmodule

// File: rtl/ascon_hash_ctrl.sv
// ascon_hash_ctrl: Ascon-Hash sponge controller (init/absorb/squeeze) around an external p12.
module ascon_hash_ctrl
   import ascon_pkg::*;
#(
   parameter int    OUT_WORDS = 4,
   parameter word_t IV        = IV_HASH
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       msg_valid,
   output logic       msg_ready,
   input  word_t      msg_data,
   input  logic       msg_last,
   input  logic [2:0] msg_bytes,
   output logic       perm_start,
   output word_t      perm_x0_o,
   output word_t      perm_x1_o,
   output word_t      perm_x2_o,
   output word_t      perm_x3_o,
   output word_t      perm_x4_o,
   input  logic       perm_done,
   input  word_t      perm_x0_i,
   input  word_t      perm_x1_i,
   input  word_t      perm_x2_i,
   input  word_t      perm_x3_i,
   input  word_t      perm_x4_i,
   output logic       dig_valid,
   input  logic       dig_ready,
   output word_t      dig_data,
   output logic       dig_last,
   output logic       busy
);
   state_t     state_q, state_d;
   word_t      x [5];
   word_t      xi [5];
   word_t      absorb;
   logic [7:0] cnt;
   logic       perm_go, perm_start_q, perm_wait, msg_hs, dig_hs, is_last;

   assign xi[0] = perm_x0_i;
   assign xi[1] = perm_x1_i;
   assign xi[2] = perm_x2_i;
   assign xi[3] = perm_x3_i;
   assign xi[4] = perm_x4_i;

   ascon_pad64 u_pad (
      .data (msg_data),
      .bytes(msg_bytes),
      .last (msg_last),
      .word (absorb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      perm_go = 1'b0;
      case (state_q)
         S_IDLE:    if (start) begin
            state_d = S_INIT;
            perm_go = 1'b1;
         end
         S_INIT:    if (perm_done) state_d = S_ABSORB;
         S_ABSORB:  if (msg_hs) begin
            state_d = msg_last ? S_FINAL : S_PERM_A;
            perm_go = 1'b1;
         end
         S_PERM_A:  if (perm_done) state_d = S_ABSORB;
         S_FINAL:   if (perm_done) state_d = S_SQUEEZE;
         S_SQUEEZE: if (dig_hs) begin
            state_d = is_last ? S_IDLE : S_PERM_S;
            perm_go = !is_last;
         end
         S_PERM_S:  if (perm_done) state_d = S_SQUEEZE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = state_q != S_IDLE;
      msg_ready  = state_q == S_ABSORB;
      dig_valid  = state_q == S_SQUEEZE;
      is_last    = cnt == 8'(OUT_WORDS - 1);
      dig_last   = dig_valid && is_last;
      dig_data   = dig_valid ? x[0] : '0;
      msg_hs     = msg_valid && msg_ready;
      dig_hs     = dig_valid && dig_ready;
      perm_wait  = state_q == S_INIT || state_q == S_PERM_A || state_q == S_FINAL || state_q == S_PERM_S;
      perm_start = perm_start_q;
      perm_x0_o  = x[0];
      perm_x1_o  = x[1];
      perm_x2_o  = x[2];
      perm_x3_o  = x[3];
      perm_x4_o  = x[4];
   end

   // state words only change on load, absorb or a permutation result, so they hold across p12
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 5; i++) x[i] <= '0;
         cnt          <= '0;
         perm_start_q <= 1'b0;
      end else begin
         perm_start_q <= perm_go;
         if (state_q == S_IDLE && start) begin
            x[0] <= IV;
            for (int i = 1; i < 5; i++) x[i] <= '0;
         end
         if (perm_wait && perm_done)
            for (int i = 0; i < 5; i++) x[i] <= xi[i];
         if (msg_hs) x[0] <= x[0] ^ absorb;
         if (state_q == S_FINAL && perm_done) cnt <= '0;
         if (dig_hs && !is_last) cnt <= cnt + 8'd1;
      end
   end
endmodule

// File: doc/ascon_hash_ctrl.md
ASCON_HASH_CTRL -- requirements
Module: ascon_hash_ctrl

Interface
REQ-001 SHALL have parameter OUT_WORDS, default 4, meaning digest length in 64-bit words (1..255).
REQ-002 SHALL have parameter IV, default 64'h00400c0000000100, meaning the x0 initialisation value (Ascon-Hash).
REQ-003 SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a new hash; sampled only in IDLE.
- msg_valid  in  1  message word valid.
- msg_ready  out  1  message word accepted when msg_valid & msg_ready.
- msg_data  in  64  message word, MSB-aligned (first message byte in bits 63:56).
- msg_last  in  1  marks the final word.
- msg_bytes  in  3  valid bytes in the final word (0..7); ignored unless msg_last.
- perm_start  out  1  one-cycle pulse requesting one p12 on perm_x*_o.
- perm_x0_o..perm_x4_o  out  64 each  state presented to the external p12.
- perm_done  in  1  one-cycle pulse: perm_x*_i valid.
- perm_x0_i..perm_x4_i  in  64 each  p12 result.
- dig_valid  out  1  digest word valid.
- dig_ready  in  1  digest word consumed when dig_valid & dig_ready.
- dig_data  out  64  digest word, first word first.
- dig_last  out  1  marks digest word OUT_WORDS-1.
- busy  out  1  high in every state except IDLE.

Function
REQ-004 SHALL implement states IDLE, INIT, ABSORB, PERM_A, FINAL, SQUEEZE, PERM_S.
REQ-005 IDLE: on start, SHALL load x0=IV and x1..x4=0, pulse perm_start, and enter INIT.
REQ-006 INIT: on perm_done, SHALL capture perm_x*_i into the state and enter ABSORB.
REQ-007 ABSORB: msg_ready SHALL be 1 only in this state.
REQ-008 On a non-last handshake, SHALL set x0 ^= msg_data, pulse perm_start next cycle, and enter PERM_A; PERM_A returns to ABSORB on perm_done.
REQ-009 On a last handshake with n=msg_bytes, SHALL set x0 ^= (msg_data & top-n-byte mask) ^ (64'h80 << (56-8n)), pulse perm_start, and enter FINAL.
REQ-010 A message whose length is a multiple of 8 SHALL end with a last word where msg_bytes=0, giving pad-only 64'h8000000000000000.
REQ-011 FINAL: on perm_done, SHALL capture the state, clear the word counter and enter SQUEEZE.
REQ-012 SQUEEZE: dig_valid=1 and dig_data=x0; dig_data SHALL stay stable while dig_ready=0.
REQ-013 On a digest handshake with counter<OUT_WORDS-1, SHALL increment the counter, pulse perm_start, and enter PERM_S; PERM_S returns to SQUEEZE on perm_done.
REQ-014 On a digest handshake with counter=OUT_WORDS-1 (dig_last=1), SHALL return to IDLE; no trailing permutation.
REQ-015 perm_x*_o SHALL equal the registered state and SHALL be stable from perm_start until perm_done.
REQ-016 Permutation latency SHALL be unconstrained (≥1 cycle); perm_done outside INIT/PERM_A/FINAL/PERM_S SHALL be ignored.
REQ-017 start while busy SHALL be ignored.
REQ-018 At most one perm_start SHALL be outstanding.
REQ-019 Words counter SHALL be 8 bits.

Reset
REQ-020 rst_n low SHALL immediately force IDLE, with state x0..x4=0, counter=0, and msg_ready=perm_start=dig_valid=dig_last=busy=0, dig_data=0.
REQ-021 Reset mid-operation SHALL abandon the hash; perm_done arriving after release SHALL be ignored.

Structure
REQ-022 Shared package ascon_pkg SHALL hold IV constants (hash, xof), the state-word width and the FSM state encoding.
REQ-023 The pad/mask function SHALL be a sub-module ascon_pad64 (combinational); p12 SHALL remain external.

Verification
REQ-024 Bench: with a stub p12 (output = input, 3-cycle latency), send start, then one last word with msg_bytes=0; SHALL see x0 absorb 64'h00400c0000000100^64'h8000000000000000, then 4 digest words, dig_last on the 4th, 3 perm_start pulses in SQUEEZE.
REQ-025 Bench: with the real p12, empty message and OUT_WORDS=4; SHALL give a digest matching the golden Ascon-Hash model, 7346BC14F036E87A... .
REQ-026 Bench: 3-byte message 0x010203 (msg_data=64'h0102030000000000, msg_bytes=3, garbage in low bytes); SHALL absorb 64'h0102038000000000 and match the golden model.
REQ-027 Bench: hold dig_ready=0 for 10 cycles on word 1; dig_data SHALL stay stable and no perm_start SHALL occur.
REQ-028 Bench: assert rst_n low during PERM_A, then a late perm_done after release; SHALL stay in IDLE with all outputs 0.
REQ-029 Bench: pulse start during ABSORB; SHALL cause no state change.
